// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full/fill/overflow flags of an async FIFO.
// Ports: i_wclk/i_wrst (async active-high) clock/reset; i_winc write request;
// i_rptr_gray read-domain Gray pointer; o_waddr memory write address;
// o_wptr_gray Gray write pointer to read domain; o_wfull full; o_wcount fill
// level; o_wovf sticky overflow; o_wafull almost-full (only with
// WPTR_ALMOST_FULL_EN defined).
module fifo_wptr_full #(
  parameter int P_WIDTH  = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic               i_wclk,
  input  logic               i_wrst,
  input  logic               i_winc,
  input  logic [P_WIDTH:0]   i_rptr_gray,
  output logic [P_WIDTH-1:0] o_waddr,
  output logic [P_WIDTH:0]   o_wptr_gray,
  output logic               o_wfull,
  output logic [P_WIDTH:0]   o_wcount,
  output logic               o_wovf
`ifdef WPTR_ALMOST_FULL_EN
  ,output logic              o_wafull
`endif
);
  logic [P_WIDTH:0] r_wbin, r_wgray, r_rq1, r_rq2, r_wcount;
  logic             r_wfull, r_wovf;
  logic             w_wen;
  logic [P_WIDTH:0] w_wbin_nxt, w_wgray_nxt, w_rbin_s, w_wcount_nxt;
  assign w_wen        = i_winc & ~r_wfull;
  assign w_wbin_nxt   = r_wbin + (P_WIDTH+1)'(w_wen);
  assign w_wgray_nxt  = (w_wbin_nxt >> 1) ^ w_wbin_nxt;
  assign w_wcount_nxt = w_wbin_nxt - w_rbin_s;
  always_comb begin
    w_rbin_s = '0;
    for (int i = 0; i <= P_WIDTH; i++) w_rbin_s[i] = ^(r_rq2 >> i);
  end
  always_ff @(posedge i_wclk or posedge i_wrst) begin
    if (i_wrst) begin
      r_wbin   <= '0;
      r_wgray  <= '0;
      r_rq1    <= '0;
      r_rq2    <= '0;
      r_wcount <= '0;
      r_wfull  <= 1'b0;
      r_wovf   <= 1'b0;
    end else begin
      r_rq1    <= i_rptr_gray;
      r_rq2    <= r_rq1;
      r_wbin   <= w_wbin_nxt;
      r_wgray  <= w_wgray_nxt;
      r_wcount <= w_wcount_nxt;
      // full when write pointer is one lap ahead: top two Gray bits inverted
      r_wfull  <= w_wgray_nxt == {~r_rq2[P_WIDTH:P_WIDTH-1], r_rq2[P_WIDTH-2:0]};
      r_wovf   <= r_wovf | (i_winc & r_wfull);
    end
  end
`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [P_WIDTH:0] L_DEPTH = (P_WIDTH+1)'(1 << P_WIDTH);
  localparam logic [P_WIDTH:0] L_AF    = (P_WIDTH+1)'(AF_LEVEL);
  logic r_wafull;
  always_ff @(posedge i_wclk or posedge i_wrst) begin
    if (i_wrst) r_wafull <= 1'b0;
    else r_wafull <= (L_DEPTH - w_wcount_nxt) <= L_AF;
  end
  assign o_wafull = r_wafull;
`endif
  assign o_waddr     = r_wbin[P_WIDTH-1:0];
  assign o_wptr_gray = r_wgray;
  assign o_wfull     = r_wfull;
  assign o_wcount    = r_wcount;
  assign o_wovf      = r_wovf;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scoreboard bench for fifo_wptr_full against a count-based model.
module tb_fifo_wptr_full;
  logic       clk = 1'b0, rst = 1'b1, winc = 1'b0;
  logic [4:0] rptr_gray = '0;
  logic [3:0] waddr;
  logic [4:0] wptr_gray, wcount;
  logic       wfull, wovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic       wafull;
`endif
  fifo_wptr_full #(.P_WIDTH(4), .AF_LEVEL(2)) dut (
    .i_wclk(clk), .i_wrst(rst), .i_winc(winc), .i_rptr_gray(rptr_gray),
    .o_waddr(waddr), .o_wptr_gray(wptr_gray), .o_wfull(wfull),
    .o_wcount(wcount), .o_wovf(wovf)
`ifdef WPTR_ALMOST_FULL_EN
    , .o_wafull(wafull)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int addr, gray, full, cnt, ovf, afull;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int wr = 0, rcnt = 0, full = 0, ovf = 0;
  int hist[$];
  function automatic logic [4:0] gray(int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: total accepted writes vs read count seen two edges late.
  task automatic step(input bit w, input bit rd);
    int rs, cnt;
    exp_t e;
    winc = w;
    if (rd) rcnt++;
    rptr_gray = gray(rcnt);
    @(posedge clk);
    rs = hist.size() >= 2 ? hist[hist.size()-2] : 0;
    hist.push_back(rcnt);
    if (w && full != 0) ovf = 1;
    if (w && full == 0) wr++;
    cnt = wr - rs;
    full = cnt == 16 ? 1 : 0;
    e.addr = wr % 16; e.gray = int'(gray(wr)); e.full = full;
    e.cnt = cnt; e.ovf = ovf; e.afull = (16 - cnt) <= 2 ? 1 : 0;
    q.push_back(e);
    #1;
  endtask
  logic [4:0] prev_g = '0;
  always @(negedge clk) begin
    if (rst) prev_g = '0;
    else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("waddr", int'(waddr), e.addr);
      chk("wptr_gray", int'(wptr_gray), e.gray);
      chk("wfull", int'(wfull), e.full);
      chk("wcount", int'(wcount), e.cnt);
      chk("wovf", int'(wovf), e.ovf);
`ifdef WPTR_ALMOST_FULL_EN
      chk("wafull", int'(wafull), e.afull);
`endif
      chk("gray_hamming_le1", $countones(prev_g ^ wptr_gray) <= 1 ? 1 : 0, 1);
      chk("wcount_le16", int'(wcount) <= 16 ? 1 : 0, 1);
      prev_g = wptr_gray;
    end
  end
  task automatic chk_reset(string tag);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_wptr_gray"}, int'(wptr_gray), 0);
    chk({tag, "_wfull"}, int'(wfull), 0);
    chk({tag, "_wcount"}, int'(wcount), 0);
    chk({tag, "_wovf"}, int'(wovf), 0);
`ifdef WPTR_ALMOST_FULL_EN
    chk({tag, "_wafull"}, int'(wafull), 0);
`endif
  endtask
  task automatic model_reset();
    wr = 0; rcnt = 0; full = 0; ovf = 0;
    hist.delete();
    winc = 1'b0;
    rptr_gray = '0;
  endtask
  task automatic random_phase(int n, int wp, int rp);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < wp, rcnt < wr && $urandom_range(99) < rp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    @(negedge clk);
    chk("filled_wfull", int'(wfull), 1);
    chk("filled_wptr_gray", int'(wptr_gray), 5'b11000);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_sticky", int'(wovf), 1);
    chk("ovf_waddr_frozen", int'(waddr), 0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    @(negedge clk);
    chk("after_read_wfull", int'(wfull), 0);
    chk("after_read_wcount", int'(wcount), 15);
    while (rcnt < wr) step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    random_phase(150, 85, 30);
    random_phase(150, 30, 85);
    random_phase(300, 60, 60);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    random_phase(200, 70, 50);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
